// File: rtl/mem_stage.sv
// RV64I memory-access stage: forwards ALU results to write-back, or runs a req/ack
// data-memory transaction for loads and stores while holding the upstream pipeline.
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [63:0]           res_i,
  input  logic                  alu_write_back_en_i,
  input  logic [4:0]            rd_i,
  input  logic                  load_flag_i,
  input  logic                  mem_en_i,
  input  logic [2:0]            funct3_i,
  input  logic [63:0]           store_data_i,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [63:0]           mem_rdata,
  output logic                  wb_en,
  output logic [4:0]            wb_rd,
  output logic [63:0]           wb_data,
  output logic                  stall_o,
  output logic                  misalign_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_next;

  logic        op_load;
  logic [4:0]  op_rd;
  logic [2:0]  op_funct3;
  logic [2:0]  op_off;

  logic [2:0]  off;
  logic        legal;
  logic        aligned;
  logic        accept;
  logic        reject;
  logic [7:0]  strb_base;
  logic [63:0] rdata_shifted;
  logic [63:0] load_value;

  assign off = res_i[2:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Illegal size encodings are folded into the misaligned path.
  always_comb begin
    legal      = load_flag_i ? (funct3_i != 3'b111) : !funct3_i[2];
    aligned    = 1'b1;
    strb_base  = 8'h01;
    case (funct3_i[1:0])
      2'b00:   begin aligned = 1'b1;           strb_base = 8'h01; end
      2'b01:   begin aligned = !off[0];        strb_base = 8'h03; end
      2'b10:   begin aligned = (off[1:0] == 2'b00); strb_base = 8'h0F; end
      default: begin aligned = (off == 3'b000); strb_base = 8'hFF; end
    endcase
    accept     = (state == IDLE) && mem_en_i && legal && aligned;
    reject     = (state == IDLE) && mem_en_i && !(legal && aligned);
    stall_o    = ((state == IDLE) && mem_en_i) || (state == BUSY);
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = BUSY;
      default: if (mem_ack) state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_shifted = mem_rdata >> {op_off, 3'b000};
    case (op_funct3)
      3'b000:  load_value = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
      3'b001:  load_value = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  load_value = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'b100:  load_value = {56'b0, rdata_shifted[7:0]};
      3'b101:  load_value = {48'b0, rdata_shifted[15:0]};
      3'b110:  load_value = {32'b0, rdata_shifted[31:0]};
      default: load_value = rdata_shifted;
    endcase
  end

  // Bus outputs stay frozen throughout BUSY; only the ack edge changes them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      wb_en      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign_o <= 1'b0;
      op_load    <= 1'b0;
      op_rd      <= '0;
      op_funct3  <= '0;
      op_off     <= '0;
    end else begin
      wb_en      <= 1'b0;
      misalign_o <= 1'b0;
      if (state == IDLE) begin
        if (!mem_en_i) begin
          wb_en   <= alu_write_back_en_i && (rd_i != 5'd0);
          wb_rd   <= rd_i;
          wb_data <= res_i;
        end else if (accept) begin
          op_load   <= load_flag_i;
          op_rd     <= rd_i;
          op_funct3 <= funct3_i;
          op_off    <= off;
          mem_req   <= 1'b1;
          mem_we    <= !load_flag_i;
          mem_addr  <= {res_i[ADDR_WIDTH-1:3], 3'b000};
          mem_wstrb <= load_flag_i ? 8'h00 : (strb_base << off);
          mem_wdata <= load_flag_i ? 64'd0 : (store_data_i << {off, 3'b000});
        end else if (reject) begin
          misalign_o <= 1'b1;
        end
      end else if (mem_ack) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 8'h00;
        if (op_load) begin
          wb_en   <= (op_rd != 5'd0);
          wb_rd   <= op_rd;
          wb_data <= load_value;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV64I pipeline. It sits directly downstream of the ALU stage and consumes its registered outputs: result/effective address, write-back enable, destination register, load flag and memory enable. Non-memory results pass through to the write-back port after one register stage. Loads and stores run a req/ack transaction on the data-memory bus, and the block holds the upstream pipeline with `stall_o` until the transaction completes.

## Interface
- `ADDR_WIDTH`, 32 — width of `mem_addr`; driven from `res_i[ADDR_WIDTH-1:0]` with bits [2:0] forced to 0.
- `CLK` in 1 — clock; all state updates on the rising edge.
- `RST` in 1 — reset, asynchronous, active-high.
- `res_i` in 64 — ALU result, or effective address when `mem_en_i`=1.
- `alu_write_back_en_i` in 1 — ALU result is to be written back.
- `rd_i` in 5 — destination register.
- `load_flag_i` in 1 — with `mem_en_i`: 1 = load, 0 = store.
- `mem_en_i` in 1 — current input is a memory operation.
- `funct3_i` in 3 — access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; stores use 000–011.
- `store_data_i` in 64 — rs2 value for stores.
- `mem_req` out 1 — bus request.
- `mem_we` out 1 — 1 = write.
- `mem_addr` out ADDR_WIDTH — doubleword-aligned address.
- `mem_wdata` out 64 — lane-shifted store data.
- `mem_wstrb` out 8 — byte enables; all 0 for reads.
- `mem_ack` in 1 — transaction complete; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 64 — read doubleword.
- `wb_en` out 1 — register-file write enable.
- `wb_rd` out 5 — register-file write address.
- `wb_data` out 64 — register-file write data.
- `stall_o` out 1 — hold the upstream stages (ALU `stall` input, and freeze decode/fetch).
- `misalign_o` out 1 — one-cycle pulse for a misaligned access.

## Operation
- States: IDLE and BUSY.
- **IDLE, `mem_en_i`=0:**
  - `wb_en` <= `alu_write_back_en_i` & (`rd_i` != 0).
  - `wb_rd` <= `rd_i`; `wb_data` <= `res_i`.
- **IDLE, `mem_en_i`=1, aligned access:**
  - Latch op, rd, funct3 and offset `off` = `res_i[2:0]`; go to BUSY.
  - Drive `mem_req` <= 1 and `mem_addr` <= {`res_i[ADDR_WIDTH-1:3]`, 3'b0}.
  - `mem_we` <= !`load_flag_i`; `wb_en` <= 0.
- **Store lanes:**
  - `mem_wdata` = `store_data_i` << (8·`off`).
  - `mem_wstrb` = 0x01, 0x03, 0x0F or 0xFF (for B/H/W/D), shifted left by `off`.
- **Alignment rule:**
  - H requires `off[0]`=0; W requires `off[1:0]`=0; D requires `off`=0.
  - A violation issues no request and stays in IDLE.
  - It pulses `misalign_o`=1 for one cycle with `wb_en`=0.
- **BUSY:** `mem_req` and all bus outputs are held stable until `mem_ack`=1 at a rising edge. On that edge:
  - Go to IDLE; `mem_req` <= 0.
  - Load: `wb_data` <= extend(`mem_rdata` >> 8·`off`) and `wb_en` <= (rd != 0).
    - B/H/W: sign-extend from bit 7/15/31.
    - BU/HU/WU: zero-extend.
    - D: unchanged.
  - Store: `wb_en` <= 0.
- While in BUSY, `wb_en` = 0 and the ALU-side inputs are ignored; upstream presents bubbles.
- `mem_ack` arriving while in IDLE is ignored.
- A load to x0 still performs the bus read; there is no write-back.
- Illegal funct3 (store 1xx, load 111) is treated as a misaligned access.
- **Reset (any time, including mid-transaction):**
  - State -> IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `wb_en`, `wb_rd`, `wb_data`, `misalign_o` all 0.
  - A late ack from the aborted transaction is ignored.

## Timing
- `stall_o` is combinational: (IDLE & `mem_en_i`) | BUSY. It is high in the accept cycle and throughout BUSY, and low the cycle after the ack edge.
- Non-memory latency: 1 cycle, input to `wb_*`.
- Memory op accepted at edge E0:
  - `mem_req`=1 from E0 to Ek, where Ek is the first edge with `mem_ack`=1 (k ≥ 1).
  - `wb_*` is valid for one cycle after Ek.
  - Minimum load-to-write-back is 2 cycles.
- `wb_en` is a single-cycle pulse per instruction.
- `misalign_o` is high for exactly the cycle after the accept edge.

## Test plan
- Pass-through: `res_i`=0x1234, `rd_i`=5, `alu_write_back_en_i`=1, `mem_en_i`=0 -> next cycle `wb_en`=1, `wb_rd`=5, `wb_data`=0x1234, `stall_o`=0. Same input with `rd_i`=0 -> `wb_en`=0.
- LB: address 0x1003, `mem_rdata`=0x0000_0000_8000_0000, ack after 3 cycles.
  - `mem_addr`=0x1000, `mem_we`=0, `stall_o` high 4 cycles.
  - Result: `wb_data`=0xFFFF_FFFF_FFFF_FF80. Repeat as LBU -> 0x80.
- SH: address 0x2006, `store_data_i`=0xBEEF -> `mem_wstrb`=0xC0, `mem_wdata`=0xBEEF_0000_0000_0000, `mem_we`=1; after ack, `wb_en`=0.
- LW at 0x3002 -> `misalign_o` pulse, no `mem_req`, `wb_en`=0, back in IDLE. LD at 0x3008 with `mem_rdata`=0x0123_4567_89AB_CDEF -> `wb_data` equals `mem_rdata`.
- Assert `RST` while BUSY waiting for ack -> all outputs 0 immediately. An ack pulse after reset release -> no `wb_en`; a following pass-through op completes normally.
- Back-to-back: store then load, each acked in 1 cycle -> two separate transactions, `stall_o` released between them, load write-back correct.
